// File: rtl/playseq_gravador_sequencia_if.sv
// Bundle of the recorder's control, button, read-port and status signals.
// The master drives the controls; the recorder is the slave.
interface playseq_gravador_sequencia_if;
  logic       iniciar;
  logic       concluir;
  logic [3:0] botoes;
  logic [3:0] endereco_leitura;
  logic [3:0] dado_leitura;
  logic [3:0] tamanho;
  logic       pronto;
  logic       gravando;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    output iniciar, concluir, botoes, endereco_leitura,
    input  dado_leitura, tamanho, pronto, gravando, erro, db_estado
  );

  modport slave (
    input  iniciar, concluir, botoes, endereco_leitura,
    output dado_leitura, tamanho, pronto, gravando, erro, db_estado
  );
endinterface

// File: rtl/playseq_gravador_sequencia.sv
// Records up to 16 one-hot button plays into a 16x4 memory, closing on request,
// on the 16th play or after TIMEOUT idle cycles; memory is readable at any time.
module playseq_gravador_sequencia #(
  parameter int TIMEOUT = 5000
) (
  input  logic                          clock,
  input  logic                          reset,
  playseq_gravador_sequencia_if.slave   bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    ESPERA_JOGADA = 4'd1,
    REGISTRA      = 4'd2,
    ESPERA_SOLTAR = 4'd3,
    FINALIZADO    = 4'd4
  } state_t;

  state_t      r_state;
  logic [3:0]  r_endereco_escrita;
  logic [3:0]  r_tamanho;
  logic [3:0]  r_capturado;
  logic [TW-1:0] r_timeout;
  logic        r_prev_any;
  logic        r_pronto;
  logic        r_gravando;
  logic        r_erro;
  logic [3:0]  r_db_estado;
  logic [3:0]  r_mem [16];
  logic [3:0]  r_dado_leitura;

  logic w_press;
  logic w_onehot;
  logic w_timeout_hit;
  logic w_write;

  assign w_press       = ~r_prev_any & (|bus.botoes);
  assign w_onehot      = (bus.botoes & (bus.botoes - 4'd1)) == 4'd0;
  assign w_timeout_hit = r_timeout == TW'(TIMEOUT - 1);
  // iniciar takes priority over the pending write of REGISTRA.
  assign w_write       = (r_state == REGISTRA) && !bus.iniciar;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= OCIOSO;
      r_endereco_escrita <= '0;
      r_tamanho          <= '0;
      r_capturado        <= '0;
      r_timeout          <= '0;
      r_prev_any         <= 1'b0;
      r_pronto           <= 1'b0;
      r_gravando         <= 1'b0;
      r_erro             <= 1'b0;
      r_db_estado        <= OCIOSO;
    end else begin
      r_prev_any <= |bus.botoes;
      r_erro     <= 1'b0;
      if (bus.iniciar) begin
        r_state            <= ESPERA_JOGADA;
        r_db_estado        <= ESPERA_JOGADA;
        r_endereco_escrita <= '0;
        r_tamanho          <= '0;
        r_timeout          <= '0;
        r_pronto           <= 1'b0;
        r_gravando         <= 1'b1;
      end else begin
        unique case (r_state)
          ESPERA_JOGADA: begin
            if (w_press) begin
              r_capturado <= bus.botoes;
              r_timeout   <= '0;
              if (w_onehot) begin
                r_state     <= REGISTRA;
                r_db_estado <= REGISTRA;
              end else begin
                r_erro      <= 1'b1;
                r_state     <= ESPERA_SOLTAR;
                r_db_estado <= ESPERA_SOLTAR;
              end
            end else if (bus.concluir || w_timeout_hit) begin
              r_timeout  <= '0;
              r_gravando <= 1'b0;
              if (r_endereco_escrita != 4'd0) begin
                r_state     <= FINALIZADO;
                r_db_estado <= FINALIZADO;
                r_pronto    <= 1'b1;
              end else begin
                r_erro      <= 1'b1;
                r_state     <= OCIOSO;
                r_db_estado <= OCIOSO;
              end
            end else begin
              r_timeout <= r_timeout + TW'(1);
            end
          end
          REGISTRA: begin
            r_tamanho          <= r_endereco_escrita;
            r_endereco_escrita <= r_endereco_escrita + 4'd1;
            r_timeout          <= '0;
            if (r_endereco_escrita == 4'd15) begin
              r_state     <= FINALIZADO;
              r_db_estado <= FINALIZADO;
              r_pronto    <= 1'b1;
              r_gravando  <= 1'b0;
            end else begin
              r_state     <= ESPERA_SOLTAR;
              r_db_estado <= ESPERA_SOLTAR;
            end
          end
          ESPERA_SOLTAR: begin
            r_timeout <= '0;
            if (bus.botoes == 4'd0) begin
              r_state     <= ESPERA_JOGADA;
              r_db_estado <= ESPERA_JOGADA;
            end
          end
          OCIOSO, FINALIZADO: ;
          default: begin
            r_state     <= OCIOSO;
            r_db_estado <= OCIOSO;
            r_gravando  <= 1'b0;
            r_pronto    <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: the memory is cleared by reset, so it is built from flops rather
  // than a RAM macro; the read register returns the pre-write word on collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
      r_dado_leitura <= '0;
    end else begin
      r_dado_leitura <= r_mem[bus.endereco_leitura];
      if (w_write) r_mem[r_endereco_escrita] <= r_capturado;
    end
  end

  assign bus.dado_leitura = r_dado_leitura;
  assign bus.tamanho      = r_tamanho;
  assign bus.pronto       = r_pronto;
  assign bus.gravando     = r_gravando;
  assign bus.erro         = r_erro;
  assign bus.db_estado    = r_db_estado;

endmodule

// File: tb/tb_playseq_gravador_sequencia.sv
// Directed bench for the play recorder, built with TIMEOUT=8 so the idle close is reachable.
module tb_playseq_gravador_sequencia;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  playseq_gravador_sequencia_if bus ();

  playseq_gravador_sequencia #(.TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold a button pattern, release it, and let the FSM get back to ESPERA_JOGADA.
  task automatic press(input logic [3:0] v, input int hold);
    bus.botoes = v;
    tick(hold);
    bus.botoes = 4'd0;
    tick(2);
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [3:0] exp);
    bus.endereco_leitura = addr;
    tick(1);
    check(tag, bus.dado_leitura, exp);
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.concluir = 1'b0;
    bus.botoes = 4'd0;
    bus.endereco_leitura = 4'd0;
    #2;
    check("rst_db_estado", bus.db_estado, 4'd0);
    check("rst_tamanho",   bus.tamanho,   4'd0);
    check("rst_flags",     {bus.pronto, bus.gravando, bus.erro}, 3'b000);
    check("rst_dado",      bus.dado_leitura, 4'd0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Three plays, early close, read-back.
    bus.iniciar = 1'b1; tick(1); bus.iniciar = 1'b0;
    check("t1_start_db", bus.db_estado, 4'd1);
    check("t1_start_grav", bus.gravando, 1'b1);
    press(4'b0001, 3);
    check("t1_tam_after1", bus.tamanho, 4'd0);
    press(4'b0010, 3);
    press(4'b0100, 3);
    check("t1_tam_after3", bus.tamanho, 4'd2);
    check("t1_pronto_open", bus.pronto, 1'b0);
    bus.concluir = 1'b1; tick(1); bus.concluir = 1'b0;
    check("t1_pronto", bus.pronto, 1'b1);
    check("t1_db_fin", bus.db_estado, 4'd4);
    check("t1_grav_off", bus.gravando, 1'b0);
    check("t1_tamanho", bus.tamanho, 4'd2);
    check("t1_erro", bus.erro, 1'b0);
    read_check("t1_rd0", 4'd0, 4'b0001);
    bus.endereco_leitura = 4'd1;
    #1;
    check("t1_rd_latency", bus.dado_leitura, 4'b0001);
    tick(1);
    check("t1_rd1", bus.dado_leitura, 4'b0010);
    read_check("t1_rd2", 4'd2, 4'b0100);

    // Sixteen plays close automatically; a 17th press and concluir are ignored.
    bus.iniciar = 1'b1; tick(1); bus.iniciar = 1'b0;
    check("t2_clear_pronto", bus.pronto, 1'b0);
    check("t2_clear_tam", bus.tamanho, 4'd0);
    for (int i = 0; i < 15; i++) press(4'b0001 << (i % 4), 1);
    check("t2_db_before16", bus.db_estado, 4'd1);
    check("t2_tam_before16", bus.tamanho, 4'd14);
    press(4'b1000, 1);
    check("t2_db_fin", bus.db_estado, 4'd4);
    check("t2_pronto", bus.pronto, 1'b1);
    check("t2_tamanho", bus.tamanho, 4'd15);
    press(4'b0010, 2);
    bus.concluir = 1'b1; tick(1); bus.concluir = 1'b0;
    check("t2_ign_db", bus.db_estado, 4'd4);
    check("t2_ign_tam", bus.tamanho, 4'd15);
    check("t2_ign_erro", bus.erro, 1'b0);
    read_check("t2_rd15", 4'd15, 4'b1000);
    read_check("t2_rd14", 4'd14, 4'b0100);
    read_check("t2_rd0",  4'd0,  4'b0001);

    // Idle timeout with nothing recorded.
    bus.iniciar = 1'b1; tick(1); bus.iniciar = 1'b0;
    tick(7);
    check("t3_still_open", bus.db_estado, 4'd1);
    check("t3_no_erro_yet", bus.erro, 1'b0);
    tick(1);
    check("t3_erro", bus.erro, 1'b1);
    check("t3_db_ocioso", bus.db_estado, 4'd0);
    check("t3_pronto", bus.pronto, 1'b0);
    check("t3_grav", bus.gravando, 1'b0);
    tick(1);
    check("t3_erro_pulse", bus.erro, 1'b0);

    // Invalid chord, then a valid play.
    bus.iniciar = 1'b1; tick(1); bus.iniciar = 1'b0;
    bus.botoes = 4'b0011; tick(1);
    check("t4_erro", bus.erro, 1'b1);
    check("t4_db_soltar", bus.db_estado, 4'd3);
    tick(1);
    check("t4_erro_pulse", bus.erro, 1'b0);
    tick(1);
    bus.botoes = 4'd0; tick(2);
    press(4'b1000, 3);
    bus.concluir = 1'b1; tick(1); bus.concluir = 1'b0;
    check("t4_pronto", bus.pronto, 1'b1);
    check("t4_tamanho", bus.tamanho, 4'd0);
    read_check("t4_rd0", 4'd0, 4'b1000);

    // Long hold writes once; press beats concluir in the same cycle.
    bus.iniciar = 1'b1; tick(1); bus.iniciar = 1'b0;
    press(4'b0001, 20);
    check("t5_hold_tam", bus.tamanho, 4'd0);
    check("t5_hold_db", bus.db_estado, 4'd1);
    bus.botoes = 4'b0100; bus.concluir = 1'b1; tick(1); bus.concluir = 1'b0;
    check("t5_press_wins", bus.db_estado, 4'd2);
    bus.botoes = 4'd0; tick(2);
    check("t5_open_db", bus.db_estado, 4'd1);
    check("t5_open_pronto", bus.pronto, 1'b0);
    check("t5_tam", bus.tamanho, 4'd1);
    bus.concluir = 1'b1; tick(1); bus.concluir = 1'b0;
    check("t5_closed", bus.pronto, 1'b1);
    read_check("t5_rd0", 4'd0, 4'b0001);
    read_check("t5_rd1", 4'd1, 4'b0100);

    // Reset while waiting for release after two writes.
    bus.iniciar = 1'b1; tick(1); bus.iniciar = 1'b0;
    press(4'b0010, 2);
    bus.botoes = 4'b0100; tick(2);
    check("t6_pre_db", bus.db_estado, 4'd3);
    reset = 1'b1;
    #1;
    check("t6_rst_db", bus.db_estado, 4'd0);
    check("t6_rst_tam", bus.tamanho, 4'd0);
    check("t6_rst_flags", {bus.pronto, bus.gravando, bus.erro}, 3'b000);
    check("t6_rst_dado", bus.dado_leitura, 4'd0);
    bus.botoes = 4'd0;
    tick(1);
    reset = 1'b0;
    read_check("t6_rd0", 4'd0, 4'd0);
    read_check("t6_rd1", 4'd1, 4'd0);
    check("t6_idle_db", bus.db_estado, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/playseq_gravador_sequencia.md
PLAYSEQ_GRAVADOR_SEQUENCIA -- requirements
Module: playseq_gravador_sequencia

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 5000, meaning idle cycles in recording before automatic close (5 s at 1 kHz).
REQ-002 The block SHALL have the port clock, input, 1 bit: system clock, all state on rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high.
REQ-004 The block SHALL have the port iniciar, input, 1 bit: level sampled per cycle; starts a new recording.
REQ-005 The block SHALL have the port concluir, input, 1 bit: player request to close the recording early.
REQ-006 The block SHALL have the port botoes, input, 4 bits: raw button levels, one bit per colour.
REQ-007 The block SHALL have the port endereco_leitura, input, 4 bits: read address from the game datapath.
REQ-008 The block SHALL have the port dado_leitura, output, 4 bits: registered read data.
REQ-009 The block SHALL have the port tamanho, output, 4 bits: index of last recorded play (count-1), same encoding as the sequence-limit counter load value.
REQ-010 The block SHALL have the port pronto, output, 1 bit: recorded sequence valid and stable.
REQ-011 The block SHALL have the port gravando, output, 1 bit: recording in progress.
REQ-012 The block SHALL have the port erro, output, 1 bit: one-cycle pulse on invalid press or empty close.
REQ-013 The block SHALL have the port db_estado, output, 4 bits: FSM state code for 7-segment debug.

Function
REQ-014 Storage SHALL be 16 words x 4 bits; write address from internal 4-bit counter endereco_escrita.
REQ-015 FSM states and codes SHALL be: OCIOSO=0, ESPERA_JOGADA=1, REGISTRA=2, ESPERA_SOLTAR=3, FINALIZADO=4.
REQ-016 Press detection SHALL be a registered rising edge of |botoes (0 in previous cycle, nonzero now); the botoes value of the edge cycle is captured.
REQ-017 iniciar=1 in any state SHALL, on the next edge, clear endereco_escrita, tamanho, pronto and the timeout counter, and enter ESPERA_JOGADA; RAM contents are not cleared.
REQ-018 In ESPERA_JOGADA, gravando=1, the timeout counter increments each cycle.
REQ-019 In ESPERA_JOGADA, a press with one-hot value SHALL go to REGISTRA; a press with more than one bit set SHALL pulse erro, write nothing, and go to ESPERA_SOLTAR.
REQ-020 REGISTRA SHALL last exactly one cycle: write the captured value at endereco_escrita, set tamanho=endereco_escrita, increment endereco_escrita.
REQ-021 From REGISTRA, if the written address was 15 (16th play) the FSM SHALL go to FINALIZADO; otherwise to ESPERA_SOLTAR.
REQ-022 ESPERA_SOLTAR SHALL hold the timeout counter at 0 and return to ESPERA_JOGADA in the cycle after botoes==0 is seen.
REQ-023 In ESPERA_JOGADA, concluir=1 or timeout counter reaching TIMEOUT-1 SHALL close: to FINALIZADO if at least one play was recorded, else pulse erro and go to OCIOSO.
REQ-024 Simultaneous events in ESPERA_JOGADA: iniciar > press > concluir > timeout.
REQ-025 FINALIZADO SHALL hold pronto=1, gravando=0, tamanho frozen, until iniciar; presses and concluir ignored.
REQ-026 pronto SHALL be 0 in all states except FINALIZADO.
REQ-027 Read port SHALL be synchronous: dado_leitura = RAM[endereco_leitura] one cycle later; a read of the address being written in REGISTRA returns the old value.
REQ-028 Reads SHALL be permitted in every state without affecting the FSM.

Reset
REQ-029 reset=1 SHALL immediately force OCIOSO, endereco_escrita=0, timeout counter=0, edge-detector history=0, tamanho=0, pronto=0, gravando=0, erro=0, dado_leitura=0, db_estado=0, and clear all 16 RAM words to 0.
REQ-030 Reset asserted mid-recording SHALL discard the recording; no write occurs in a cycle where reset is high.

Verification
REQ-031 Reset, iniciar pulse, presses 0001,0010,0100 each held 3 cycles with release, concluir -> pronto=1, tamanho=2, reads 0..2 return 0001,0010,0100 one cycle after address.
REQ-032 16 one-hot presses -> FINALIZADO after 16th REGISTRA without concluir, tamanho=15, 17th press ignored, RAM[15] correct.
REQ-033 iniciar then no input, TIMEOUT=8 -> erro pulse once after 8 cycles in ESPERA_JOGADA, state OCIOSO, pronto=0.
REQ-034 Press 0011 then 1000 then concluir -> erro pulse on 0011, tamanho=0, RAM[0]=1000.
REQ-035 Button held 20 cycles -> exactly one write; press and concluir in same cycle -> press recorded, recording stays open.
REQ-036 reset asserted during ESPERA_SOLTAR after 2 writes -> all outputs 0 immediately, reads of 0..1 return 0000.
